// File: rtl/axi4l_gpio_pkg.sv
// Shared constants for the AXI4-Lite GPIO register block: register offsets,
// response codes, FSM state encodings and the address decoder.
package axi4l_gpio_pkg;

  localparam logic [31:0] OFF_DATA_OUT   = 32'h00;
  localparam logic [31:0] OFF_DIR        = 32'h04;
  localparam logic [31:0] OFF_DATA_IN    = 32'h08;
  localparam logic [31:0] OFF_IRQ_EN     = 32'h0C;
  localparam logic [31:0] OFF_IRQ_STATUS = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  typedef enum logic [2:0] {
    SEL_DATA_OUT, SEL_DIR, SEL_DATA_IN, SEL_IRQ_EN, SEL_IRQ_STATUS, SEL_NONE
  } reg_sel_e;

  // Exact match only, so misaligned addresses fall through to SEL_NONE.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      OFF_DATA_OUT:   sel = SEL_DATA_OUT;
      OFF_DIR:        sel = SEL_DIR;
      OFF_DATA_IN:    sel = SEL_DATA_IN;
      OFF_IRQ_EN:     sel = SEL_IRQ_EN;
      OFF_IRQ_STATUS: sel = SEL_IRQ_STATUS;
      default:        sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
    return mask;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer for asynchronous GPIO inputs plus a rising-edge
// detector on the synchronized value.
module gpio_in_sync #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] gpio_in,
  output logic [width-1:0] sync,
  output logic [width-1:0] rise
);

  logic [width-1:0] meta;
  logic [width-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= gpio_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/axi4l_gpio_regs.sv
// AXI4-Lite slave exposing GPIO output, direction, input and interrupt
// registers, with independent write and read channel FSMs.
module axi4l_gpio_regs #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int gpio_width = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [addr_width-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [data_width-1:0]   WDATA,
  input  logic [data_width/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [addr_width-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [data_width-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  input  logic [gpio_width-1:0]   gpio_in,
  output logic [gpio_width-1:0]   gpio_out,
  output logic [gpio_width-1:0]   gpio_oe,
  output logic                    irq
);
  import axi4l_gpio_pkg::*;

  logic [1:0]            w_state;
  logic [0:0]            r_state;
  logic [31:0]           aw_addr;
  logic [gpio_width-1:0] data_out, dir, irq_en, irq_status;
  logic [gpio_width-1:0] din_sync, din_rise, st_clear;
  logic [31:0]           wr_mask, wr_bits, rd_val;
  reg_sel_e              wr_sel, rd_sel;
  logic                  wr_fire;

  gpio_in_sync #(.width(gpio_width)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .sync    (din_sync),
    .rise    (din_rise)
  );

  function automatic logic [gpio_width-1:0] merge(
    input logic [gpio_width-1:0] old, input logic [31:0] mask, input logic [31:0] bits
  );
    logic [31:0] v;
    v = (32'(old) & ~mask) | bits;
    return v[gpio_width-1:0];
  endfunction

  assign wr_sel   = decode_addr(aw_addr);
  assign wr_fire  = (w_state == W_DATA) && WVALID;
  assign wr_mask  = strb_to_mask(WSTRB);
  assign wr_bits  = WDATA & wr_mask;
  assign st_clear = (wr_fire && wr_sel == SEL_IRQ_STATUS) ? wr_bits[gpio_width-1:0] : '0;
  assign rd_sel   = decode_addr(32'(ARADDR));

  always_comb begin
    rd_val = '0;
    case (rd_sel)
      SEL_DATA_OUT:   rd_val = 32'(data_out);
      SEL_DIR:        rd_val = 32'(dir);
      SEL_DATA_IN:    rd_val = 32'(din_sync);
      SEL_IRQ_EN:     rd_val = 32'(irq_en);
      SEL_IRQ_STATUS: rd_val = 32'(irq_status);
      default:        rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_IDLE;
      aw_addr  <= '0;
      BRESP    <= RESP_OKAY;
      data_out <= '0;
      dir      <= '0;
      irq_en   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (AWVALID) begin
          aw_addr <= 32'(AWADDR);
          w_state <= W_DATA;
        end
        W_DATA: if (WVALID) begin
          BRESP   <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
          w_state <= W_RESP;
          case (wr_sel)
            SEL_DATA_OUT: data_out <= merge(data_out, wr_mask, wr_bits);
            SEL_DIR:      dir      <= merge(dir, wr_mask, wr_bits);
            SEL_IRQ_EN:   irq_en   <= merge(irq_en, wr_mask, wr_bits);
            default:      ;
          endcase
        end
        W_RESP: if (BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // A fresh edge in the same cycle as a W1C clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~st_clear) | din_rise;
      irq        <= |(irq_status & irq_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (ARVALID) begin
          RDATA   <= rd_val;
          RRESP   <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
          r_state <= R_DATA;
        end
        default: if (RREADY) r_state <= R_IDLE;
      endcase
    end
  end

  assign AWREADY  = (w_state == W_IDLE) && !rst;
  assign WREADY   = (w_state == W_DATA);
  assign BVALID   = (w_state == W_RESP);
  assign ARREADY  = (r_state == R_IDLE) && !rst;
  assign RVALID   = (r_state == R_DATA);
  assign gpio_out = data_out;
  assign gpio_oe  = dir;

endmodule

// File: tb/tb_axi4l_gpio_regs.sv
// Randomized self-checking bench for axi4l_gpio_regs against a register-level
// reference model of the GPIO block.
module tb_axi4l_gpio_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] gpio_in, gpio_out, gpio_oe;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_dout, m_dir, m_ien, m_ist;

  always #5 clk = ~clk;

  axi4l_gpio_regs #(.addr_width(32), .data_width(32), .gpio_width(32)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  // Reference model: registers as plain words, byte lanes applied one by one.
  function automatic logic [31:0] byte_merge(input logic [31:0] old, data, input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_mapped(input logic [31:0] addr);
    return addr == 32'h0 || addr == 32'h4 || addr == 32'h8 || addr == 32'hC || addr == 32'h10;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, data, input logic [3:0] strb);
    if (!is_mapped(addr)) return 2'b10;
    if (addr == 32'h0) m_dout = byte_merge(m_dout, data, strb);
    if (addr == 32'h4) m_dir = byte_merge(m_dir, data, strb);
    if (addr == 32'hC) m_ien = byte_merge(m_ien, data, strb);
    if (addr == 32'h10) m_ist = m_ist & ~byte_merge(32'h0, data, strb);
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    case (addr)
      32'h0:   return m_dout;
      32'h4:   return m_dir;
      32'h8:   return gpio_in;
      32'hC:   return m_ien;
      32'h10:  return m_ist;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    m_dout = 0; m_dir = 0; m_ien = 0; m_ist = 0;
  endfunction

  task automatic axi_write(input logic [31:0] addr, data, input logic [3:0] strb, output logic [1:0] resp);
    int n;
    AWADDR = addr; AWVALID = 1'b1; n = 0;
    while (!AWREADY && n < 50) begin @(negedge clk); n++; end
    if (!AWREADY) begin vectors++; miscompares++; $display("[TB] FAIL timeout_awready: awready=%b required 1", AWREADY); end
    @(negedge clk);
    AWVALID = 1'b0; WDATA = data; WSTRB = strb; WVALID = 1'b1; n = 0;
    while (!WREADY && n < 50) begin @(negedge clk); n++; end
    if (!WREADY) begin vectors++; miscompares++; $display("[TB] FAIL timeout_wready: wready=%b required 1", WREADY); end
    @(negedge clk);
    WVALID = 1'b0; BREADY = 1'b1; n = 0;
    while (!BVALID && n < 50) begin @(negedge clk); n++; end
    if (!BVALID) begin vectors++; miscompares++; $display("[TB] FAIL timeout_bvalid: bvalid=%b required 1", BVALID); end
    resp = BRESP;
    @(negedge clk);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    ARADDR = addr; ARVALID = 1'b1; n = 0;
    while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    if (!ARREADY) begin vectors++; miscompares++; $display("[TB] FAIL timeout_arready: arready=%b required 1", ARREADY); end
    @(negedge clk);
    ARVALID = 1'b0; RREADY = 1'b1; n = 0;
    while (!RVALID && n < 50) begin @(negedge clk); n++; end
    if (!RVALID) begin vectors++; miscompares++; $display("[TB] FAIL timeout_rvalid: rvalid=%b required 1", RVALID); end
    data = RDATA; resp = RRESP;
    @(negedge clk);
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    AWADDR = 0; WDATA = 0; WSTRB = 0; ARADDR = 0; gpio_in = 0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, irq} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake: aw/w/b/ar/r/irq=%b required 000000", {AWREADY, WREADY, BVALID, ARREADY, RVALID, irq});
    end
    vectors++;
    if ({BRESP, RRESP, RDATA, gpio_out, gpio_oe} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: bresp=%b rresp=%b rdata=%h out=%h oe=%h required all 0", BRESP, RRESP, RDATA, gpio_out, gpio_oe);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_ready: awready=%b arready=%b required 1 1", AWREADY, ARREADY);
    end
  endtask

  task automatic test_data_out();
    logic [1:0] resp, rresp;
    logic [31:0] d;
    axi_write(32'h0, 32'hA5A5_A5A5, 4'hF, resp);
    void'(model_write(32'h0, 32'hA5A5_A5A5, 4'hF));
    vectors++;
    if (resp !== 2'b00) begin miscompares++; $display("[TB] FAIL dout_bresp: got %b required 00", resp); end
    axi_read(32'h0, d, rresp);
    vectors++;
    if (d !== 32'hA5A5_A5A5 || rresp !== 2'b00) begin
      miscompares++; $display("[TB] FAIL dout_read: got %h/%b required a5a5a5a5/00", d, rresp);
    end
    vectors++;
    if (gpio_out !== 32'hA5A5_A5A5) begin miscompares++; $display("[TB] FAIL dout_pins: got %h required a5a5a5a5", gpio_out); end
  endtask

  task automatic test_dir_strobe();
    logic [1:0] resp, rresp;
    logic [31:0] d;
    axi_write(32'h4, 32'hFFFF_FFFF, 4'b0010, resp);
    void'(model_write(32'h4, 32'hFFFF_FFFF, 4'b0010));
    vectors++;
    if (resp !== 2'b00 || gpio_oe !== 32'h0000_FF00) begin
      miscompares++; $display("[TB] FAIL dir_strobe: bresp=%b oe=%h required 00 0000ff00", resp, gpio_oe);
    end
    axi_read(32'h4, d, rresp);
    vectors++;
    if (d !== m_dir) begin miscompares++; $display("[TB] FAIL dir_read: got %h required %h", d, m_dir); end
    // Zero strobes: OKAY but nothing written.
    axi_write(32'h0, 32'h1234_5678, 4'b0000, resp);
    vectors++;
    if (resp !== 2'b00 || gpio_out !== m_dout) begin
      miscompares++; $display("[TB] FAIL zero_strobe: bresp=%b out=%h required 00 %h", resp, gpio_out, m_dout);
    end
  endtask

  task automatic test_slverr();
    logic [1:0] resp, rresp;
    logic [31:0] d;
    axi_write(32'h20, 32'hDEAD_BEEF, 4'hF, resp);
    vectors++;
    if (resp !== 2'b10) begin miscompares++; $display("[TB] FAIL slverr_write: got %b required 10", resp); end
    axi_write(32'h2, 32'hDEAD_BEEF, 4'hF, resp);
    vectors++;
    if (resp !== 2'b10) begin miscompares++; $display("[TB] FAIL slverr_misaligned: got %b required 10", resp); end
    axi_read(32'h6, d, rresp);
    vectors++;
    if (rresp !== 2'b10) begin miscompares++; $display("[TB] FAIL slverr_read: got %b required 10", rresp); end
    for (int a = 0; a <= 16; a += 4) begin
      axi_read(a, d, rresp);
      vectors++;
      if (d !== model_read(a) || rresp !== 2'b00) begin
        miscompares++; $display("[TB] FAIL slverr_nochange_%0h: got %h/%b required %h/00", a, d, rresp, model_read(a));
      end
    end
  endtask

  task automatic test_sync_latency();
    logic [1:0] rresp;
    logic [31:0] d;
    for (int dly = 1; dly <= 2; dly++) begin
      gpio_in[dly + 1] = 1'b1;
      m_ist[dly + 1] = 1'b1;
      repeat (dly) @(negedge clk);
      axi_read(32'h8, d, rresp);
      vectors++;
      if (d[dly + 1] !== (dly == 2)) begin
        miscompares++; $display("[TB] FAIL sync_latency_%0d: got %b required %b", dly, d[dly + 1], dly == 2);
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_irq();
    logic [1:0] resp, rresp;
    logic [31:0] d;
    axi_write(32'hC, 32'h1, 4'hF, resp);
    void'(model_write(32'hC, 32'h1, 4'hF));
    gpio_in[0] = 1'b1;
    m_ist[0] = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_early: got %b required 0", irq); end
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_rise: got %b required 1", irq); end
    axi_read(32'h10, d, rresp);
    vectors++;
    if (d !== m_ist) begin miscompares++; $display("[TB] FAIL irq_status: got %h required %h", d, m_ist); end
    axi_write(32'h10, 32'h1, 4'hF, resp);
    void'(model_write(32'h10, 32'h1, 4'hF));
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_clear: got %b required 0", irq); end
  endtask

  task automatic test_backpressure();
    AWADDR = 32'h20; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0; AWADDR = 32'h0; AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (BVALID !== 1'b1 || BRESP !== 2'b10 || AWREADY !== 1'b0) begin
        miscompares++; $display("[TB] FAIL b_stall_%0d: bvalid=%b bresp=%b awready=%b required 1 10 0", i, BVALID, BRESP, AWREADY);
      end
      @(negedge clk);
    end
    AWVALID = 1'b0; BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    vectors++;
    if (AWREADY !== 1'b1 || gpio_out !== m_dout) begin
      miscompares++; $display("[TB] FAIL b_stall_after: awready=%b out=%h required 1 %h", AWREADY, gpio_out, m_dout);
    end
    ARADDR = 32'h0; ARVALID = 1'b1;
    @(negedge clk);
    ARADDR = 32'h4;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (RVALID !== 1'b1 || RDATA !== m_dout || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
        miscompares++; $display("[TB] FAIL r_stall_%0d: rvalid=%b rdata=%h arready=%b required 1 %h 0", i, RVALID, RDATA, ARREADY, m_dout);
      end
      @(negedge clk);
    end
    ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [31:0] old, nv;
    old = m_dout; nv = $urandom;
    AWADDR = 32'h0; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WDATA = nv; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h0; ARVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    vectors++;
    if (RVALID !== 1'b1 || RDATA !== old) begin
      miscompares++; $display("[TB] FAIL same_cycle_read: rvalid=%b rdata=%h required 1 %h", RVALID, RDATA, old);
    end
    void'(model_write(32'h0, nv, 4'hF));
    @(negedge clk);
    BREADY = 1'b0; RREADY = 1'b0;
    vectors++;
    if (gpio_out !== m_dout) begin miscompares++; $display("[TB] FAIL same_cycle_write: got %h required %h", gpio_out, m_dout); end
  endtask

  task automatic test_random();
    logic [31:0] addrs [11] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20, 32'h1, 32'h6, 32'h100, 32'hFFFF_FFF0};
    logic [31:0] a, d, got, nin;
    logic [3:0]  s;
    logic [1:0]  resp, exp_resp;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        nin = $urandom;
        m_ist = m_ist | (nin & ~gpio_in);
        gpio_in = nin;
        repeat (5) @(negedge clk);
      end
      a = addrs[$urandom_range(0, 10)];
      d = $urandom;
      s = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        axi_write(a, d, s, resp);
        exp_resp = model_write(a, d, s);
        vectors++;
        if (resp !== exp_resp || gpio_out !== m_dout || gpio_oe !== m_dir) begin
          miscompares++;
          $display("[TB] FAIL rand_write_%0d @%h: bresp=%b out=%h oe=%h required %b %h %h", i, a, resp, gpio_out, gpio_oe, exp_resp, m_dout, m_dir);
        end
      end else begin
        axi_read(a, got, resp);
        exp_resp = is_mapped(a) ? 2'b00 : 2'b10;
        vectors++;
        if (resp !== exp_resp || (exp_resp == 2'b00 && got !== model_read(a))) begin
          miscompares++;
          $display("[TB] FAIL rand_read_%0d @%h: rdata=%h rresp=%b required %h %b", i, a, got, resp, model_read(a), exp_resp);
        end
      end
      vectors++;
      if (irq !== |(m_ist & m_ien)) begin
        miscompares++; $display("[TB] FAIL rand_irq_%0d: got %b required %b", i, irq, |(m_ist & m_ien));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    logic [1:0]  rresp;
    gpio_in = 32'h0;
    repeat (4) @(negedge clk);
    AWADDR = 32'h0; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WDATA = 32'h5A5A_0001; WSTRB = 4'hF; WVALID = 1'b1; rst = 1'b1;
    @(negedge clk);
    WVALID = 1'b0;
    model_reset();
    vectors++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b0 || gpio_out !== 32'h0) begin
      miscompares++; $display("[TB] FAIL midreset_hold: bvalid=%b awready=%b out=%h required 0 0 0", BVALID, AWREADY, gpio_out);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (AWREADY !== 1'b1 || BVALID !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midreset_release: awready=%b bvalid=%b required 1 0", AWREADY, BVALID);
    end
    axi_read(32'h0, d, rresp);
    vectors++;
    if (d !== 32'h0 || rresp !== 2'b00) begin
      miscompares++; $display("[TB] FAIL midreset_noupdate: got %h/%b required 00000000/00", d, rresp);
    end
  endtask

  initial begin
    test_reset();
    test_data_out();
    test_dir_strobe();
    test_slverr();
    test_sync_latency();
    test_irq();
    test_backpressure();
    test_same_cycle();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4l_gpio_regs.md
AXI4L_GPIO_REGS -- requirements
Module: axi4l_gpio_regs

Interface
REQ-001 SHALL have parameter addr_width, default 32, AXI address width.
REQ-002 SHALL have parameter data_width, default 32, AXI data width; only 32 is supported.
REQ-003 SHALL have parameter gpio_width, default 32, number of GPIO pins (1..32).
REQ-004 SHALL use one clock and a synchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-005 SHALL have write-address ports: AWADDR input addr_width; AWVALID input 1; AWREADY output 1.
REQ-006 SHALL have write-data ports: WDATA input data_width; WSTRB input data_width/8 (byte enables); WVALID input 1; WREADY output 1.
REQ-007 SHALL have write-response ports: BRESP output 2; BVALID output 1; BREADY input 1.
REQ-008 SHALL have read-address ports: ARADDR input addr_width; ARVALID input 1; ARREADY output 1.
REQ-009 SHALL have read-data ports: RDATA output data_width; RRESP output 2; RVALID output 1; RREADY input 1.
REQ-010 SHALL have GPIO ports: gpio_in input gpio_width (asynchronous pins); gpio_out output gpio_width; gpio_oe output gpio_width (1 = drive); irq output 1 (level interrupt).

Function
REQ-011 SHALL decode register map: 0x00 DATA_OUT RW; 0x04 DIR RW (drives gpio_oe); 0x08 DATA_IN RO; 0x0C IRQ_EN RW; 0x10 IRQ_STATUS W1C; bits above gpio_width read 0, ignore writes.
REQ-012 SHALL respond OKAY (2'b00) for mapped aligned addresses, SLVERR (2'b10) for unmapped or AWADDR/ARADDR[1:0] != 0, with no register side effect on SLVERR.
REQ-013 SHALL implement write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
REQ-014 W_IDLE: AWREADY=1; on AWVALID&&AWREADY latch AWADDR, go W_DATA.
REQ-015 W_DATA: WREADY=1; on WVALID&&WREADY update the addressed register at that edge per WSTRB bytes, go W_RESP.
REQ-016 W_RESP: BVALID=1, BRESP held stable until BVALID&&BREADY, then W_IDLE; AWREADY and WREADY stay 0.
REQ-017 WSTRB=4'b0000 SHALL write nothing and return OKAY.
REQ-018 SHALL implement read FSM R_IDLE -> R_DATA -> R_IDLE, independent of the write FSM.
REQ-019 R_IDLE: ARREADY=1; on ARVALID&&ARREADY register RDATA/RRESP, go R_DATA (RVALID=1 the next cycle, 1-cycle latency).
REQ-020 R_DATA: RVALID=1, RDATA/RRESP stable until RVALID&&RREADY, then R_IDLE; ARREADY=0.
REQ-021 SHALL pass gpio_in through a 2-flop synchronizer; DATA_IN reads the synchronized value (change visible 2 clocks after gpio_in).
REQ-022 SHALL set IRQ_STATUS[i] on a rising edge of synchronized gpio_in[i] (one clock after DATA_IN[i] goes 1).
REQ-023 SHALL clear IRQ_STATUS[i] on a write with WDATA[i]=1 and its byte strobed; a set event in the same cycle wins.
REQ-024 SHALL drive irq = |(IRQ_STATUS & IRQ_EN), registered (1 clock after the status/enable change).
REQ-025 SHALL drive gpio_out = DATA_OUT and gpio_oe = DIR directly from registers.
REQ-026 A read and write to the same register in the same cycle SHALL return the pre-write value.

Reset
REQ-027 On rst=1 at a clock edge: both FSMs to idle; AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, irq=0.
REQ-028 Reset SHALL clear DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, synchronizer and edge-detect flops to 0; gpio_oe=0 (all inputs).
REQ-029 Reset mid-transaction SHALL abandon it with no register update and no response issued.
REQ-030 AWREADY/ARREADY SHALL assert the first cycle after rst deasserts.

Structure
REQ-031 Package axi4l_gpio_pkg SHALL hold register offsets, RESP_OKAY/RESP_SLVERR constants and the write/read state enums.
REQ-032 Sub-module gpio_in_sync SHALL contain the 2-flop synchronizer and rising-edge detector (outputs: sync value, edge pulse).

Verification
REQ-033 Write 0x00 data 0xA5A5_A5A5 WSTRB 4'hF, then read 0x00 -> BRESP=00; RDATA=0xA5A5_A5A5; gpio_out=0xA5A5_A5A5.
REQ-034 Write 0x04 data 0xFFFF_FFFF WSTRB 4'b0010 -> DIR=0x0000_FF00; gpio_oe matches; BRESP=00.
REQ-035 Write to 0x20 and read 0x06 -> BRESP=10, RRESP=10, no register changed.
REQ-036 IRQ_EN=0x1; gpio_in[0] 0->1 -> DATA_IN[0]=1 after 2 clocks, IRQ_STATUS[0]=1 one clock later, irq=1 one clock after; write 0x10 data 0x1 -> irq=0.
REQ-037 Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and BRESP/RDATA stable; no new AW/AR accepted.
REQ-038 Assert rst during W_DATA -> no update, BVALID=0, AWREADY=1 first cycle after reset release.
